// File: rtl/ucore_port_fifo_pkg.sv
// ucore_port_fifo_pkg: shared defaults for the ucore output-port FIFO.
// Carries the ucore data-width default, the default depth and the level-width helper.
// The overflow feature is controlled by the UCORE_PORT_FIFO_OVF_EN macro and is off by default.
package ucore_port_fifo_pkg;

  localparam int UCORE_DATA_W = 8;
  localparam int UPF_DEPTH    = 4;

  // Occupancy needs to represent 0..DEPTH inclusive.
  function automatic int upf_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ucore_port_fifo_if.sv
// ucore_port_fifo_if: bundle between the ucore/consumer side (master) and the FIFO (slave).
// The write side is driven by the ucore, the m_* side is read by the consumer.
interface ucore_port_fifo_if
  import ucore_port_fifo_pkg::*;
#(
  parameter int WIDTH = UCORE_DATA_W,
  parameter int DEPTH = UPF_DEPTH
);
  localparam int LW = upf_lvl_w(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             almost_full;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic [LW-1:0]    level;
  logic             ovf;
  logic [7:0]       ovf_count;
  logic             ovf_clear;

  modport master (
    output wr_en, wr_data, m_ready, ovf_clear,
    input  full, almost_full, m_valid, m_data, level, ovf, ovf_count
  );

  modport slave (
    input  wr_en, wr_data, m_ready, ovf_clear,
    output full, almost_full, m_valid, m_data, level, ovf, ovf_count
  );

endinterface

// File: rtl/ucore_port_fifo_mem.sv
// ucore_port_fifo_mem: DEPTH x WIDTH register array, one write port, one async read port.
// Storage is deliberately not reset; the top gates the read data with its valid flag.
module ucore_port_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write the addressed entry on each accepted push.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/ucore_port_fifo.sv
// ucore_port_fifo: buffers ucore output-port writes and presents them over valid/ready
// with first-word fall-through. full/almost_full/level are registered from the next-state
// level so the ucore can self-throttle on them.
// Optional feature: define UCORE_PORT_FIFO_OVF_EN to build the sticky overflow flag and
// the saturating dropped-write counter; otherwise they read as 0 and cost no flops.
module ucore_port_fifo
  import ucore_port_fifo_pkg::*;
#(
  parameter int WIDTH       = UCORE_DATA_W,
  parameter int DEPTH       = UPF_DEPTH,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic             clk,
  input  logic             aresetn,
  ucore_port_fifo_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = upf_lvl_w(DEPTH);
  localparam logic [LW-1:0] L_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] L_AFULL = LW'(AFULL_LEVEL);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_full;
  logic             r_afull;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic [LW-1:0]    w_level_nxt;
  logic [WIDTH-1:0] w_rd_data;

  // A write while full is dropped even if a pop frees a slot on the same edge,
  // because the ucore only ever sees the registered full flag.
  assign w_valid = (r_level != '0);
  assign w_push  = bus.wr_en & ~r_full;
  assign w_pop   = w_valid & bus.m_ready;

  // Next-state occupancy; push+pop leaves it unchanged.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Pointers, level and flags; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == L_DEPTH);
      r_afull <= (w_level_nxt >= L_AFULL);
    end
  end

  ucore_port_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_push),
    .wr_addr (r_wr_ptr),
    .wr_data (bus.wr_data),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_data)
  );

  assign bus.m_valid     = w_valid;
  assign bus.m_data      = w_valid ? w_rd_data : '0;
  assign bus.full        = r_full;
  assign bus.almost_full = r_afull;
  assign bus.level       = r_level;

`ifdef UCORE_PORT_FIFO_OVF_EN
  logic       r_ovf;
  logic [7:0] r_ovf_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Sticky overflow and saturating drop count; clear wins over a same-cycle drop.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (bus.ovf_clear) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (bus.wr_en & r_full) begin
      r_ovf     <= 1'b1;
      r_ovf_cnt <= sat_inc8(r_ovf_cnt);
    end
  end

  assign bus.ovf       = r_ovf;
  assign bus.ovf_count = r_ovf_cnt;
`else
  logic w_unused_ovf_clear;
  assign w_unused_ovf_clear = bus.ovf_clear;
  assign bus.ovf            = 1'b0;
  assign bus.ovf_count      = '0;
`endif

endmodule

// File: tb/tb_ucore_port_fifo.sv
// tb_ucore_port_fifo: directed bench for ucore_port_fifo (DEPTH=4, WIDTH=8).
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_ucore_port_fifo;

`ifdef UCORE_PORT_FIFO_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic clk;
  logic aresetn;
  int   n_vec;
  int   n_err;

  ucore_port_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

  ucore_port_fifo #(.WIDTH(8), .DEPTH(4), .AFULL_LEVEL(3)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int lvl, input logic [7:0] head);
    chk({tag, "_level"}, 32'(bus.level), 32'(lvl));
    chk({tag, "_valid"}, 32'(bus.m_valid), 32'(lvl != 0));
    chk({tag, "_data"}, 32'(bus.m_data), 32'(head));
    chk({tag, "_afull"}, 32'(bus.almost_full), 32'(lvl >= 3));
    chk({tag, "_full"}, 32'(bus.full), 32'(lvl == 4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int sent, recvd, exp_next;
    bit prev_stall, rdy, do_push;
    logic [7:0] prev_data;

    n_vec = 0;
    n_err = 0;

    // 1: reset with wr_en held, then first push
    aresetn       = 1'b0;
    bus.wr_en     = 1'b1;
    bus.wr_data   = 8'h55;
    bus.m_ready   = 1'b0;
    bus.ovf_clear = 1'b0;
    repeat (3) tick();
    chk_flags("t1_rst", 0, 8'h00);
    chk("t1_rst_ovf", 32'(bus.ovf), 32'd0);
    chk("t1_rst_ovfc", 32'(bus.ovf_count), 32'd0);
    bus.wr_data = 8'hA5;
    aresetn     = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    chk_flags("t1_push", 1, 8'hA5);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk_flags("t1_pop", 0, 8'h00);

    // 2: fill to full, then one dropped write
    for (int i = 1; i <= 4; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      tick();
      chk_flags($sformatf("t2_fill%0d", i), i, 8'h01);
    end
    bus.wr_data = 8'h05;
    tick();
    chk_flags("t2_drop", 4, 8'h01);
    chk("t2_ovf", 32'(bus.ovf), 32'(OVF));
    chk("t2_ovfc", 32'(bus.ovf_count), OVF ? 32'd1 : 32'd0);

    // 3: full with pop and write on the same edge -> write dropped
    bus.m_ready = 1'b1;
    bus.wr_data = 8'h06;
    tick();
    bus.wr_en   = 1'b0;
    bus.m_ready = 1'b0;
    chk_flags("t3", 3, 8'h02);
    chk("t3_ovfc", 32'(bus.ovf_count), OVF ? 32'd2 : 32'd0);
    bus.ovf_clear = 1'b1;
    tick();
    bus.ovf_clear = 1'b0;
    chk("t3_clr_ovf", 32'(bus.ovf), 32'd0);
    chk("t3_clr_ovfc", 32'(bus.ovf_count), 32'd0);
    chk_flags("t3_hold", 3, 8'h02);

    // 4: level 2, push and pop every cycle, pointers wrap
    bus.m_ready = 1'b1;
    tick();
    chk_flags("t4_pre", 2, 8'h03);
    q = '{8'h03, 8'h04};
    for (int i = 0; i < 10; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h10 + i);
      tick();
      q.push_back(8'(8'h10 + i));
      void'(q.pop_front());
      chk_flags($sformatf("t4_c%0d", i), 2, q[0]);
    end
    bus.wr_en = 1'b0;
    repeat (2) tick();
    bus.m_ready = 1'b0;
    chk_flags("t4_drain", 0, 8'h00);

    // 5: random backpressure, 100 pushes gated by the model's full
    q.delete();
    sent = 0; recvd = 0; exp_next = 1;
    prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 2000 && recvd < 100; cyc++) begin
      chk("t5_level", 32'(bus.level), 32'(q.size()));
      chk("t5_valid", 32'(bus.m_valid), 32'(q.size() != 0));
      chk("t5_full", 32'(bus.full), 32'(q.size() == 4));
      if (q.size() != 0) chk("t5_head", 32'(bus.m_data), 32'(exp_next));
      if (prev_stall) chk("t5_stable", 32'(bus.m_data), 32'(prev_data));
      rdy     = 1'($urandom_range(0, 1));
      do_push = (sent < 100) && (q.size() < 4);
      bus.m_ready = rdy;
      bus.wr_en   = do_push;
      bus.wr_data = 8'(sent + 1);
      prev_stall  = (q.size() != 0) && !rdy;
      prev_data   = 8'(exp_next);
      tick();
      if (q.size() != 0 && rdy) begin
        void'(q.pop_front());
        recvd++;
        exp_next++;
      end
      if (do_push) begin
        q.push_back(8'(sent + 1));
        sent++;
      end
    end
    bus.wr_en   = 1'b0;
    bus.m_ready = 1'b0;
    chk("t5_recv", 32'(recvd), 32'd100);
    chk_flags("t5_end", 0, 8'h00);

    // 6: async reset mid-operation, then a fresh push
    for (int i = 0; i < 3; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h21 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    chk_flags("t6_pre", 3, 8'h21);
    #2;
    aresetn = 1'b0;
    #1;
    chk_flags("t6_async", 0, 8'h00);
    tick();
    aresetn     = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h77;
    tick();
    bus.wr_en = 1'b0;
    chk_flags("t6_push", 1, 8'h77);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk_flags("t6_pop", 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
